// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for the UART RX path: show-ahead storage, frame-error
// counter, sticky overrun flag and a level-threshold interrupt.
module uart_rx_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [7:0]    data_i,
   input  logic          rx_int_i,
   input  logic          err_int_i,
   input  logic          rd_en_i,
   input  logic          flush_i,
   input  logic          clr_status_i,
   input  logic [AW:0]   thresh_i,
   output logic [7:0]    rd_data_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [AW:0]   level_o,
   output logic          overrun_o,
   output logic [7:0]    err_cnt_o,
   output logic          thresh_irq_o
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [7:0]  CNT_ONE = 8'd1;
   localparam logic [7:0]  CNT_MAX = 8'hFF;

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [AW:0] wr_nxt, rd_nxt, level_nxt;
   logic        empty_q, full_q;
   logic        push_ok, pop_ok, drop;
   logic        irq_nxt;

   // Bus-side handshake: ~empty_o acts as valid for rd_data_o, rd_en_i as ready;
   // a pop happens only on a cycle where both are high, rd_en_i alone is ignored.
   always_comb begin
      pop_ok    = rd_en_i & ~empty_q & ~flush_i;
      // A pop on a full FIFO frees the slot the incoming byte needs.
      push_ok   = rx_int_i & (~full_q | pop_ok) & ~flush_i;
      drop      = rx_int_i & full_q & ~pop_ok & ~flush_i;
      wr_nxt    = wr_ptr;
      rd_nxt    = rd_ptr;
      if (flush_i) begin
         wr_nxt = '0;
         rd_nxt = '0;
      end else begin
         if (push_ok) wr_nxt = wr_ptr + PTR_ONE;
         if (pop_ok)  rd_nxt = rd_ptr + PTR_ONE;
      end
      level_nxt = wr_nxt - rd_nxt;
      irq_nxt   = (thresh_i != '0) && (level_nxt >= thresh_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level_o      <= '0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         thresh_irq_o <= 1'b0;
      end else begin
         wr_ptr       <= wr_nxt;
         rd_ptr       <= rd_nxt;
         level_o      <= level_nxt;
         empty_q      <= (wr_nxt == rd_nxt);
         full_q       <= (wr_nxt[AW] != rd_nxt[AW]) &&
                         (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
         thresh_irq_o <= irq_nxt;
      end
   end

   // Status: a new event in the same cycle as clr_status_i survives the clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overrun_o <= 1'b0;
         err_cnt_o <= '0;
      end else begin
         if (drop)
            overrun_o <= 1'b1;
         else if (clr_status_i)
            overrun_o <= 1'b0;

         if (err_int_i) begin
            if (clr_status_i)
               err_cnt_o <= CNT_ONE;
            else if (err_cnt_o != CNT_MAX)
               err_cnt_o <= err_cnt_o + CNT_ONE;
         end else if (clr_status_i) begin
            err_cnt_o <= '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok)
         mem[wr_ptr[AW-1:0]] <= data_i;
   end

   assign empty_o   = empty_q;
   assign full_o    = full_q;
   assign rd_data_o = empty_q ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART RX data path. Captures each good byte, signalled by the data path's one-cycle rx_int pulse, into a show-ahead FIFO. Counts frame errors, signalled by err_int pulses, and flags overrun. Exposes level, threshold interrupt and a pop interface to the register/bus side.

Parameters:
DEPTH, 16, number of byte entries; power of two, >= 2
AW, $clog2(DEPTH), pointer index width (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
data_i  in  8  received byte from RX data path; valid when rx_int_i=1
rx_int_i  in  1  one-cycle pulse: good byte available -> push
err_int_i  in  1  one-cycle pulse: parity/CRC error on a frame
rd_en_i  in  1  pop request from bus side
flush_i  in  1  synchronous FIFO clear
clr_status_i  in  1  clear overrun_o and err_cnt_o
thresh_i  in  AW+1  level threshold for thresh_irq_o; 0 disables
rd_data_o  out  8  head entry (show-ahead); 8'h00 when empty
empty_o  out  1  FIFO empty
full_o  out  1  FIFO holds DEPTH entries
level_o  out  AW+1  entries stored, 0..DEPTH
overrun_o  out  1  sticky: a byte was dropped because FIFO full
err_cnt_o  out  8  saturating count of err_int_i pulses
thresh_irq_o  out  1  level interrupt: level_o >= thresh_i and thresh_i != 0

Behaviour:
- Reset: pointers=0, level_o=0, empty_o=1, full_o=0, rd_data_o=0, overrun_o=0, err_cnt_o=0, thresh_irq_o=0. Memory contents not reset.
- Storage: DEPTH x 8 array. wr_ptr and rd_ptr are AW+1 bits, incremented modulo 2^(AW+1).
  - empty when pointers are equal.
  - full when index bits are equal and MSBs differ.
  - level_o = wr_ptr - rd_ptr, registered.
- Push: rx_int_i=1 and not full writes data_i at wr_ptr and advances wr_ptr.
- Pop: rd_en_i=1 and not empty advances rd_ptr. rd_en_i while empty is ignored; no state change, no error.
- Latency:
  - A byte pushed on edge N appears on rd_data_o, and empty_o falls, in the cycle after edge N.
  - rd_data_o is combinational from mem[rd_ptr], gated to 0 when empty. No read-during-write bypass is needed, because empty_o is registered.
- Simultaneous push and pop:
  - Not full, not empty: both occur; level unchanged.
  - Full: the pop frees a slot and the push is accepted; no overrun; level stays DEPTH.
  - Empty: the push occurs and the pop is ignored; level becomes 1.
- Overrun: rx_int_i while full with no accepted pop in the same cycle drops data_i. overrun_o is set the next cycle and stays set until clr_status_i or reset. flush_i does not clear it.
- Error count:
  - Each err_int_i pulse increments err_cnt_o, saturating at 8'hFF.
  - rx_int_i and err_int_i in the same cycle: push and count both happen independently.
- clr_status_i zeroes overrun_o and err_cnt_o. In a same-cycle clash the new event wins:
  - overrun_o ends at 1;
  - err_cnt_o ends at 1.
- flush_i:
  - Sets both pointers and level_o to 0; highest priority over push/pop in the same cycle; a concurrent push is discarded, not counted as overrun.
  - Does not affect err_cnt_o or overrun_o.
- thresh_irq_o: registered, updated each cycle from the next-state level, so it tracks level_o with no extra lag. Level-sensitive; deasserts when pops bring level below thresh_i. thresh_i > DEPTH means it never asserts.
- Reset mid-operation: everything returns to reset values immediately (async). The first push after rst_i deasserts is accepted normally.

Test Plan:
- Push 8'hA5, 8'h3C via rx_int_i pulses -> next cycle after first push empty_o=0, rd_data_o=A5; pop -> rd_data_o=3C, level_o=1; pop -> empty_o=1, rd_data_o=0.
- DEPTH=16: push 0x00..0x0F -> full_o=1, level_o=16; push 0xFF -> overrun_o=1, level_o=16; pop all -> 0x00..0x0F in order, 0xFF absent.
- Full FIFO, rx_int_i=1 with rd_en_i=1 (data 0x55) -> overrun_o stays 0, level_o=16, 0x55 read out last after wrap-around.
- 300 err_int_i pulses -> err_cnt_o=255. clr_status_i together with err_int_i -> err_cnt_o=1. clr_status_i alone -> 0.
- thresh_i=4: push 3 -> thresh_irq_o=0; 4th push -> 1 on same cycle level_o=4; pop one -> 0; thresh_i=0 with 16 entries -> 0.
- 5 entries, flush_i asserted together with rx_int_i and rd_en_i -> level_o=0, empty_o=1, overrun_o unchanged. Assert rst_i mid-burst -> all outputs reset; next push reads back correctly.
